// File: rtl/link_bringup_ctrl.sv
// link_bringup_ctrl: drives the MAC/GT core reset and the user-logic reset
// through hold, alignment wait, settle and run phases. Attempts that never
// align are retried a bounded number of times before parking in FAIL.
// Alignment losses seen while running are counted.
module link_bringup_ctrl #(
    parameter int unsigned RST_HOLD_CYCLES = 100,
    parameter int unsigned SETTLE_CYCLES   = 500,
    parameter int unsigned ALIGN_TIMEOUT   = 1000000,
    parameter int unsigned MAX_RETRIES     = 3
) (
    input  logic        init_clk,
    input  logic        rst_n,
    input  logic        rx_aligned,
    input  logic        restart,
    output logic        core_rst,
    output logic        usr_rst,
    output logic        link_up,
    output logic        fail,
    output logic [2:0]  state,
    output logic [15:0] link_drop_cnt
);

    localparam int unsigned MAX_RS  = (RST_HOLD_CYCLES > SETTLE_CYCLES) ? RST_HOLD_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_RS > ALIGN_TIMEOUT) ? MAX_RS : ALIGN_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] RH_LAST     = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(ALIGN_TIMEOUT - 1);
    localparam logic [7:0]       RETRY_LIM   = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_WAIT_ALIGN = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAIL       = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic [7:0]       retry_inc;
    logic [15:0]      drop_q, drop_d;
    logic             sync1_q, sync2_q;
    logic             aligned_s;
    logic             core_rst_q, usr_rst_q, link_up_q, fail_q;

    // Two-flop synchronizer for the asynchronous alignment status.
    always_ff @(posedge init_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= rx_aligned;
            sync2_q <= sync1_q;
        end
    end

    assign aligned_s = sync2_q;
    assign retry_inc = retry_q + 8'd1;

    // State, phase counter, retry count and drop count registers.
    always_ff @(posedge init_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET_HOLD;
            cnt_q   <= '0;
            retry_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic; restart overrides every other condition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        drop_d  = drop_q;
        if (restart) begin
            state_d = ST_RESET_HOLD;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RESET_HOLD: begin
                    if (cnt_q == RH_LAST) state_d = ST_WAIT_ALIGN;
                end
                ST_WAIT_ALIGN: begin
                    if (aligned_s) begin
                        state_d = ST_SETTLE;
                    end else if (cnt_q == TO_LAST) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == RETRY_LIM) ? ST_FAIL : ST_RESET_HOLD;
                    end
                end
                ST_SETTLE: begin
                    if (!aligned_s) begin
                        state_d = ST_WAIT_ALIGN;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end
                end
                ST_RUN: begin
                    if (!aligned_s) begin
                        state_d = ST_RESET_HOLD;
                        if (drop_q != '1) drop_d = drop_q + 16'd1;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RESET_HOLD;
                end
            endcase
            // A restart into RESET_HOLD from RESET_HOLD is not a state change,
            // so the counter clear for restart is handled in its own branch.
            if (state_d != state_q) cnt_d = '0;
        end
    end

    // Registered output decode of the current state.
    always_ff @(posedge init_clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rst_q <= 1'b1;
            usr_rst_q  <= 1'b1;
            link_up_q  <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            core_rst_q <= (state_q == ST_RESET_HOLD) || (state_q == ST_FAIL);
            usr_rst_q  <= (state_q != ST_RUN);
            link_up_q  <= (state_q == ST_RUN);
            fail_q     <= (state_q == ST_FAIL);
        end
    end

    assign core_rst      = core_rst_q;
    assign usr_rst       = usr_rst_q;
    assign link_up       = link_up_q;
    assign fail          = fail_q;
    assign state         = state_q;
    assign link_drop_cnt = drop_q;

endmodule

// File: doc/link_bringup_ctrl.md
LINK_BRINGUP_CTRL -- requirements
Module: link_bringup_ctrl

Interface
REQ-001 Parameter RST_HOLD_CYCLES, default 100: cycles core_rst held after each (re)start; range 1..2^20.
REQ-002 Parameter SETTLE_CYCLES, default 500: consecutive aligned cycles required before usr_rst release; range 1..2^20.
REQ-003 Parameter ALIGN_TIMEOUT, default 1000000: max WAIT_ALIGN cycles per attempt; range 1..2^24.
REQ-004 Parameter MAX_RETRIES, default 3: consecutive failed attempts before FAIL; range 1..255.
REQ-005 Port init_clk, input, 1: sole clock; all state on rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port rx_aligned, input, 1: MAC alignment status, asynchronous to init_clk.
REQ-008 Port restart, input, 1: synchronous single-cycle pulse requesting full bring-up restart.
REQ-009 Port core_rst, output, 1: active-high reset to the MAC/GT core.
REQ-010 Port usr_rst, output, 1: active-high reset to user traffic logic (converter, traffic generator/checker).
REQ-011 Port link_up, output, 1: high only in RUN.
REQ-012 Port fail, output, 1: high only in FAIL.
REQ-013 Port state, output, 3: current state encoding (REQ-016).
REQ-014 Port link_drop_cnt, output, 16: count of RUN exits caused by alignment loss.

Function
REQ-015 rx_aligned SHALL pass through a 2-flop synchronizer; aligned_s denotes its output; all decisions use aligned_s only.
REQ-016 States SHALL be RESET_HOLD=0, WAIT_ALIGN=1, SETTLE=2, RUN=3, FAIL=4; unused codes return to RESET_HOLD next cycle.
REQ-017 All outputs SHALL be registered and decoded from the registered state: core_rst=1 in RESET_HOLD and FAIL; usr_rst=0 only in RUN; link_up=(state==RUN); fail=(state==FAIL).
REQ-018 A single phase counter SHALL clear on every state transition and increment every cycle otherwise, sized for the largest of the three cycle parameters.
REQ-019 RESET_HOLD SHALL last exactly RST_HOLD_CYCLES cycles, then enter WAIT_ALIGN.
REQ-020 WAIT_ALIGN: aligned_s=1 -> SETTLE next cycle; else after ALIGN_TIMEOUT cycles -> retry_cnt+1, then FAIL if the new retry_cnt equals MAX_RETRIES, otherwise RESET_HOLD.
REQ-021 SETTLE: aligned_s=0 -> WAIT_ALIGN with the timeout restarted; else after SETTLE_CYCLES consecutive cycles -> RUN.
REQ-022 Entering RUN SHALL clear retry_cnt (internal, 8-bit).
REQ-023 RUN: aligned_s=0 -> RESET_HOLD next cycle and link_drop_cnt+1, saturating at 16'hFFFF.
REQ-024 FAIL SHALL be held until restart or reset.
REQ-025 restart=1 in any state SHALL override all other conditions: next state RESET_HOLD, counter and retry_cnt cleared; link_drop_cnt unchanged.
REQ-026 A simultaneous alignment loss and restart SHALL NOT increment link_drop_cnt.
REQ-027 Latency: rx_aligned deassert in RUN -> usr_rst=1 within 4 cycles (2 sync + 1 state + 1 output).

Reset
REQ-028 While rst_n=0: state=RESET_HOLD, core_rst=1, usr_rst=1, link_up=0, fail=0, link_drop_cnt=0, retry_cnt=0, counter=0, synchronizer flops=0.
REQ-029 rst_n assertion mid-operation (any state) SHALL force REQ-028 values asynchronously; after deassertion a full RESET_HOLD of RST_HOLD_CYCLES cycles SHALL occur.

Verification (RST_HOLD_CYCLES=4, SETTLE_CYCLES=8, ALIGN_TIMEOUT=32, MAX_RETRIES=2)
REQ-030 rx_aligned=1 constant from reset release -> core_rst falls after 4 cycles; usr_rst falls and link_up rises after 8 aligned_s cycles; link_drop_cnt=0.
REQ-031 rx_aligned=0 constant -> two 32-cycle WAIT_ALIGN windows separated by a 4-cycle core_rst pulse, then fail=1, state=4, core_rst=1, usr_rst=1 held indefinitely.
REQ-032 In RUN, drop rx_aligned for 1 cycle -> usr_rst=1 and link_up=0 within 4 cycles, link_drop_cnt=1, full re-bring-up completes once rx_aligned returns.
REQ-033 In SETTLE, glitch rx_aligned low after 5 cycles -> return to WAIT_ALIGN, usr_rst stays 1; link_up rises only after a fresh 8 consecutive aligned cycles.
REQ-034 restart pulse in FAIL and in RUN -> state=0 next cycle, core_rst=1, retry_cnt=0, link_drop_cnt unchanged.
REQ-035 rst_n pulsed low in RUN with link_drop_cnt=3 -> outputs immediately at REQ-028 values, link_drop_cnt=0.
